// File: rtl/instr_sequencer_if.sv
// Bus bundle for instr_sequencer.
//   master : drives the sequencer controls (rdy, cycle strobes, PD, interrupt lines)
//            and observes IR / cycle / interrupt status.
//   slave  : the sequencer itself.
// With INSTR_TRACE_EN defined the bundle also carries sync and retired.
interface instr_sequencer_if #(
  parameter int CYCLE_W = 3,
  parameter int OP_W    = 8
);
  logic               rdy;
  logic               I_cycle;
  logic               R_cycle;
  logic               S_cycle;
  logic [OP_W-1:0]    PD;
  logic               nmi_n;
  logic               irq_n;
  logic               i_flag;
  logic [OP_W-1:0]    IR;
  logic [CYCLE_W-1:0] cycle;
  logic [CYCLE_W-1:0] next_cycle;
  logic               int_active;
  logic [1:0]         int_src;
  logic               nmi_ack;
`ifdef INSTR_TRACE_EN
  logic               sync;
  logic [15:0]        retired;
`endif

  modport master (
    output rdy, I_cycle, R_cycle, S_cycle, PD, nmi_n, irq_n, i_flag,
`ifdef INSTR_TRACE_EN
    input  sync, retired,
`endif
    input  IR, cycle, next_cycle, int_active, int_src, nmi_ack
  );

  modport slave (
    input  rdy, I_cycle, R_cycle, S_cycle, PD, nmi_n, irq_n, i_flag,
`ifdef INSTR_TRACE_EN
    output sync, retired,
`endif
    output IR, cycle, next_cycle, int_active, int_src, nmi_ack
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction cycle counter and instruction register latch.
// Counts instruction cycles, latches the opcode from PD at the fetch boundary
// (rdy=1 and next_cycle == FETCH_CYCLE), injects BRK_OPCODE for the reset
// sequence, a pending NMI or an unmasked IRQ, and reports the source.
// Ports:
//   clk_ph1 : clock, all state on rising edge
//   rst     : synchronous reset, active low
//   bus     : instr_sequencer_if.slave (controls in, IR/cycle/status out)
// Optional: define INSTR_TRACE_EN to add bus.sync (pulse after each boundary)
// and bus.retired (16-bit count of boundaries taken in RUN).
module instr_sequencer #(
  parameter int              CYCLE_W     = 3,
  parameter int              OP_W        = 8,
  parameter int              FETCH_CYCLE = 1,
  parameter logic [OP_W-1:0] BRK_OPCODE  = '0
) (
  input  logic              clk_ph1,
  input  logic              rst,
  instr_sequencer_if.slave  bus
);
  typedef enum logic {RST_SEQ, RUN} state_e;

  localparam logic [CYCLE_W-1:0] FETCH = CYCLE_W'(FETCH_CYCLE);

  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [OP_W-1:0]    ir_q, ir_d;
  logic               act_q, act_d;
  logic [1:0]         src_q, src_d;
  logic               ack_q, ack_d;
  logic               pend_q, pend_d;
  logic               prev_q;
  logic               boundary, nmi_edge, take_nmi;

  // Cycle counter next value; rdy=0 freezes it.
  always_comb begin
    cycle_d = cycle_q;
    if (bus.rdy) begin
      if      (bus.R_cycle) cycle_d = '0;
      else if (bus.I_cycle) cycle_d = cycle_q + CYCLE_W'(1);
      else if (bus.S_cycle) cycle_d = cycle_q + CYCLE_W'(2);
    end
  end

  assign boundary = bus.rdy && (cycle_d == FETCH);
  // Edge detect runs every clock so a falling NMI is seen even while stalled.
  assign nmi_edge = prev_q & ~bus.nmi_n;

  // State register and all datapath registers.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state_q <= RST_SEQ;
      cycle_q <= '1;
      ir_q    <= '0;
      act_q   <= 1'b0;
      src_q   <= 2'b00;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      ir_q    <= ir_d;
      act_q   <= act_d;
      src_q   <= src_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      prev_q  <= bus.nmi_n;
    end
  end

  // Next state: the reset sequence lasts until its first boundary.
  always_comb begin
    state_d = state_q;
    if (state_q == RST_SEQ && boundary) state_d = RUN;
  end

  // Outputs: IR load / BRK injection at the boundary, otherwise hold.
  always_comb begin
    ir_d     = ir_q;
    act_d    = act_q;
    src_d    = src_q;
    take_nmi = 1'b0;
    if (boundary) begin
      if (state_q == RST_SEQ) begin
        // Pending NMI/IRQ deliberately left for the following boundary.
        ir_d  = BRK_OPCODE;
        act_d = 1'b1;
        src_d = 2'b11;
      end else if (pend_q) begin
        ir_d     = BRK_OPCODE;
        act_d    = 1'b1;
        src_d    = 2'b10;
        take_nmi = 1'b1;
      end else if (!bus.irq_n && !bus.i_flag) begin
        ir_d  = BRK_OPCODE;
        act_d = 1'b1;
        src_d = 2'b01;
      end else begin
        ir_d  = bus.PD;
        act_d = 1'b0;
        src_d = 2'b00;
      end
    end
    ack_d  = take_nmi;
    // A fresh edge in the acknowledge clock keeps the NMI pending.
    pend_d = nmi_edge | (pend_q & ~take_nmi);
  end

  assign bus.IR         = ir_q;
  assign bus.cycle      = cycle_q;
  assign bus.next_cycle = cycle_d;
  assign bus.int_active = act_q;
  assign bus.int_src    = src_q;
  assign bus.nmi_ack    = ack_q;

`ifdef INSTR_TRACE_EN
  logic        sync_q;
  logic [15:0] retired_q;

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      sync_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      sync_q <= boundary;
      if (boundary && state_q == RUN) retired_q <= retired_q + 16'd1;
    end
  end

  assign bus.sync    = sync_q;
  assign bus.retired = retired_q;
`endif
endmodule
